// File: rtl/danger_slot_mgr.sv
// danger_slot_mgr: N-slot obstacle spawner/mover driven by a 1-cycle game tick.
// Define DANGER_SPEED_RAMP_EN to add the spawn-count driven speed ramp.
module danger_slot_mgr #(
  parameter int N_SLOTS     = 3,
  parameter int POS_W       = 10,
  parameter int WIN_W       = 640,
  parameter int GAP_TICKS   = 511,
  parameter int SPD_W       = 3,
  parameter int RAMP_SPAWNS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       run,
  input  logic                       clear,
  input  logic [6:0]                 rnd,
  input  logic [SPD_W-1:0]           base_speed,
  output logic [N_SLOTS*POS_W-1:0]   slot_pos,
  output logic [N_SLOTS*3-1:0]       slot_type,
  output logic [N_SLOTS-1:0]         slot_en,
  output logic                       spawn_pulse,
  output logic [3:0]                 active_cnt,
  output logic [SPD_W-1:0]           cur_speed
);

  localparam int GAP_W = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [2:0] T_NOTHING = 3'd5;

`ifndef SYNTHESIS
  if (WIN_W + 77 >= (1 << POS_W)) begin : g_bad_win
    $error("danger_slot_mgr: WIN_W+77 does not fit in POS_W bits");
  end
  if (N_SLOTS < 1 || N_SLOTS > 8) begin : g_bad_slots
    $error("danger_slot_mgr: N_SLOTS must be 1..8");
  end
  if (RAMP_SPAWNS < 1) begin : g_bad_ramp
    $error("danger_slot_mgr: RAMP_SPAWNS must be >= 1");
  end
`endif

  logic               clr;
  logic               active;
  logic               all_full;
  logic               attempt;
  logic               do_spawn;
  logic [N_SLOTS-1:0] en_vec;
  logic [N_SLOTS-1:0] en_nxt;
  logic [N_SLOTS-1:0] free_vec;
  logic [N_SLOTS-1:0] spawn_sel;
  logic [POS_W-1:0]   speed_ext;
  logic [POS_W-1:0]   spawn_pos;

  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [2:0]         pend_type_q, pend_type_d;
  logic [6:0]         pend_w_q, pend_w_d;
  logic               spawn_q;
  logic [3:0]         cnt_q, cnt_d;

  assign clr       = !rst || clear;
  assign active    = tick && run;
  assign all_full  = &en_vec;
  assign attempt   = active && !all_full && (gap_q == GAP_W'(GAP_TICKS));
  assign do_spawn  = attempt && (pend_type_q != T_NOTHING);
  assign free_vec  = ~en_vec;
  // Isolate the lowest set bit of the free mask: that slot takes the spawn.
  assign spawn_sel = do_spawn ? (free_vec & (~free_vec + N_SLOTS'(1))) : '0;
  assign speed_ext = POS_W'(cur_speed);
  assign spawn_pos = POS_W'(WIN_W) + POS_W'(pend_w_q);

  always_comb begin
    gap_d = gap_q;
    if (active) begin
      if (all_full || attempt) gap_d = '0;
      else                     gap_d = gap_q + GAP_W'(1);
    end
  end

  always_comb begin
    pend_type_d = pend_type_q;
    pend_w_d    = pend_w_q;
    if (attempt) begin
      if (rnd <= 7'd50) begin
        pend_type_d = T_NOTHING; pend_w_d = 7'd0;
      end else if (rnd <= 7'd60) begin
        pend_type_d = 3'd4;      pend_w_d = 7'd27;
      end else if (rnd <= 7'd70) begin
        pend_type_d = 3'd2;      pend_w_d = 7'd19;
      end else if (rnd <= 7'd80) begin
        pend_type_d = 3'd3;      pend_w_d = 7'd77;
      end else if (rnd <= 7'd90) begin
        pend_type_d = 3'd0;      pend_w_d = 7'd44;
      end else begin
        pend_type_d = 3'd1;      pend_w_d = 7'd44;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      logic [POS_W-1:0] pos_q, pos_d;
      logic [2:0]       type_q, type_d;
      logic             en_q, en_d;

      // Freshly spawned slots skip motion; a zero speed neither moves nor retires.
      always_comb begin
        pos_d  = pos_q;
        type_d = type_q;
        en_d   = en_q;
        if (spawn_sel[gi]) begin
          pos_d  = spawn_pos;
          type_d = pend_type_q;
          en_d   = 1'b1;
        end else if (active && en_q && (cur_speed != '0)) begin
          if (pos_q > speed_ext) begin
            pos_d = pos_q - speed_ext;
          end else begin
            pos_d  = '0;
            type_d = T_NOTHING;
            en_d   = 1'b0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (clr) begin
          pos_q  <= '0;
          type_q <= T_NOTHING;
          en_q   <= 1'b0;
        end else begin
          pos_q  <= pos_d;
          type_q <= type_d;
          en_q   <= en_d;
        end
      end

      assign en_vec[gi]                   = en_q;
      assign en_nxt[gi]                   = en_d;
      assign slot_en[gi]                  = en_q;
      assign slot_pos[gi*POS_W +: POS_W]  = pos_q;
      assign slot_type[gi*3 +: 3]         = type_q;
    end
  endgenerate

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N_SLOTS; i++) cnt_d = cnt_d + 4'(en_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      gap_q       <= '0;
      pend_type_q <= T_NOTHING;
      pend_w_q    <= '0;
      spawn_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      gap_q       <= gap_d;
      pend_type_q <= pend_type_d;
      pend_w_q    <= pend_w_d;
      spawn_q     <= do_spawn;
      cnt_q       <= cnt_d;
    end
  end

  assign spawn_pulse = spawn_q;
  assign active_cnt  = cnt_q;

`ifdef DANGER_SPEED_RAMP_EN
  localparam int RC_W = (RAMP_SPAWNS < 2) ? 1 : $clog2(RAMP_SPAWNS);

  logic [RC_W-1:0]  rcnt_q;
  logic [SPD_W-1:0] ramp_q;
  logic [SPD_W:0]   speed_sum;

  // do_spawn already implies run, so the ramp is frozen while the game is stopped.
  always_ff @(posedge clk) begin
    if (clr) begin
      rcnt_q <= '0;
      ramp_q <= '0;
    end else if (do_spawn) begin
      if (rcnt_q == RC_W'(RAMP_SPAWNS - 1)) begin
        rcnt_q <= '0;
        if (ramp_q != '1) ramp_q <= ramp_q + SPD_W'(1);
      end else begin
        rcnt_q <= rcnt_q + RC_W'(1);
      end
    end
  end

  assign speed_sum = {1'b0, base_speed} + {1'b0, ramp_q};
  assign cur_speed = speed_sum[SPD_W] ? '1 : speed_sum[SPD_W-1:0];
`else
  assign cur_speed = base_speed;
`endif

endmodule
